// File: rtl/equalizer_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined signed 16x16 multiplier among
// several equalizer requesters. Each issued operation carries a tag {valid, id}
// through a pipe that tracks the multiplier. The tag returns the result to its
// issuer. An undeliverable result at the multiplier output freezes the whole
// pipe through mul_ce.
module equalizer_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 3,
  parameter int MAX_BURST   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [16*N_REQ-1:0]                req_a,
  input  logic [16*N_REQ-1:0]                req_b,
  output logic [N_REQ-1:0]                   req_ready,
  output logic [N_REQ-1:0]                   rsp_valid,
  output logic [21:0]                        rsp_data,
  input  logic [N_REQ-1:0]                   rsp_ready,
  output logic                               mul_ce,
  output logic [15:0]                        mul_din0,
  output logic [15:0]                        mul_din1,
  input  logic [21:0]                        mul_dout,
  output logic                               busy,
  output logic [$clog2(MUL_LATENCY+1)-1:0]   inflight
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MUL_LATENCY + 1);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] ID_MAX     = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Tag pipe: stage MUL_LATENCY-1 is the head, aligned with mul_dout.
  logic           tag_valid_reg [MUL_LATENCY];
  logic [IDW-1:0] tag_id_reg    [MUL_LATENCY];
  logic           head_valid;
  logic [IDW-1:0] head_id;

  // Arbiter state.
  logic [IDW-1:0] last_reg, last_next;
  logic [BW-1:0]  burst_cnt_reg, burst_cnt_next;
  logic           burst_live_reg, burst_live_next;

  // Occupancy and control state.
  logic [CW-1:0]  inflight_reg, inflight_next;
  state_t         state_reg, state_next;

  logic           grant;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx;
  logic           deliver;

  logic [15:0]    op_a [N_REQ];
  logic [15:0]    op_b [N_REQ];

  assign head_valid = tag_valid_reg[MUL_LATENCY-1];
  assign head_id    = tag_id_reg[MUL_LATENCY-1];

  // The pipe freezes only when a valid head cannot hand off to its owner.
  assign mul_ce  = !(head_valid && !rsp_ready[head_id]);
  assign deliver = head_valid && mul_ce;

  // Unpack the operand buses and build the per-requester one-hot outputs.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign op_a[gi]      = req_a[16*gi +: 16];
    assign op_b[gi]      = req_b[16*gi +: 16];
    assign req_ready[gi] = grant && (grant_id == IDW'(gi));
    assign rsp_valid[gi] = head_valid && (head_id == IDW'(gi));
  end

  // The multiplier output goes straight to the requesters. The multiplier
  // already yields the wrapped low 22 bits of the product.
  assign rsp_data = mul_dout;

  // Drive zeros into the multiplier on bubbles so idle cycles are deterministic.
  assign mul_din0 = grant ? op_a[grant_id] : 16'd0;
  assign mul_din1 = grant ? op_b[grant_id] : 16'd0;

  // Arbitration: extend the owner's burst if allowed, else round-robin from last+1.
  // The burst owner is valid only while its grants continue without a gap.
  // After reset or a bubble the search starts fresh from last+1.
  always_comb begin
    grant           = 1'b0;
    grant_id        = last_reg;
    last_next       = last_reg;
    burst_cnt_next  = burst_cnt_reg;
    burst_live_next = burst_live_reg;
    idx             = last_reg;
    if (mul_ce) begin
      if (burst_live_reg && req_valid[last_reg] && (burst_cnt_reg < BURST_LAST)) begin
        grant          = 1'b1;
        grant_id       = last_reg;
        burst_cnt_next = burst_cnt_reg + 1'b1;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (idx == ID_MAX) ? '0 : idx + 1'b1;
          if (!grant && req_valid[idx]) begin
            grant    = 1'b1;
            grant_id = idx;
          end
        end
        if (grant) begin
          last_next      = grant_id;
          burst_cnt_next = '0;
        end
      end
      burst_live_next = grant;
    end
  end

  // Occupancy: +1 on grant, -1 on head delivery. When both happen it holds.
  always_comb begin
    inflight_next = inflight_reg;
    case ({grant, deliver})
      2'b10:   inflight_next = inflight_reg + CW'(1);
      2'b01:   inflight_next = inflight_reg - CW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // Control FSM next state: IDLE when empty and quiet, STALL while frozen.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!mul_ce)
          state_next = ST_STALL;
        else if (!grant && (inflight_next == '0) && !(|req_valid))
          state_next = ST_IDLE;
      end
      ST_STALL: begin
        if (mul_ce) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Tag pipe shift. Reset drops every in-flight tag, so stale products are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tag_valid_reg[k] <= 1'b0;
        tag_id_reg[k]    <= '0;
      end
    end else if (mul_ce) begin
      tag_valid_reg[0] <= grant;
      tag_id_reg[0]    <= grant_id;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_valid_reg[k] <= tag_valid_reg[k-1];
        tag_id_reg[k]    <= tag_id_reg[k-1];
      end
    end
  end

  // Arbiter pointer and burst tracking. These hold during stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg       <= ID_MAX;
      burst_cnt_reg  <= '0;
      burst_live_reg <= 1'b0;
    end else begin
      last_reg       <= last_next;
      burst_cnt_reg  <= burst_cnt_next;
      burst_live_reg <= burst_live_next;
    end
  end

  // Occupancy counter and control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
      state_reg    <= ST_IDLE;
    end else begin
      inflight_reg <= inflight_next;
      state_reg    <= state_next;
    end
  end

  assign inflight = inflight_reg;
  assign busy     = (state_reg != ST_IDLE) || (inflight_reg != '0);

endmodule
